envelope_follower: RTL and testbench
====================================

ENVELOPE_FOLLOWER -- requirements
Module: envelope_follower

Interface
REQ-001 Parameter HOLD_SAMPLES, default 441, number of valid samples the gate stays high after the envelope drops below the off threshold (10 ms at 44100 Hz).
REQ-002 Parameter HOLD_BITS, default 16, width of the hold counter; HOLD_SAMPLES SHALL be less than 2**HOLD_BITS and at least 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 sample_valid  input  1  one-cycle strobe marking a new audio sample (nominally 44100 Hz); may be high on consecutive cycles.
REQ-006 sample  input  8  signed two's-complement audio sample, sampled when sample_valid=1.
REQ-007 a  input  4  attack shift (0 = instant, 15 = slowest).
REQ-008 r  input  4  release shift (0 = instant, 15 = slowest).
REQ-009 on_thresh  input  8  unsigned envelope level that opens the gate.
REQ-010 off_thresh  input  8  unsigned envelope level below which the hold phase starts.
REQ-011 envelope  output  8  unsigned smoothed amplitude, bits [15:8] of the internal accumulator.
REQ-012 env_valid  output  1  one-cycle pulse, high the cycle after each accepted sample.
REQ-013 gate  output  1  note-present indication, compatible with the ADSR generator gate input.

Function
REQ-014 Rectification: rect = |sample|; sample = -128 SHALL saturate to 127.
REQ-015 Internal accumulator acc is 16-bit unsigned (8.8 fixed point); target = rect << 8.
REQ-016 On each sample_valid: if target > acc, acc <= acc + ((target - acc) >> a); if target < acc, acc <= acc - ((acc - target) >> r); if equal, unchanged.
REQ-017 If the shifted difference is 0 but target != acc, acc SHALL step 1 LSB toward target, guaranteeing convergence.
REQ-018 acc SHALL never wrap; the result is bounded to [0, 0x7F00].
REQ-019 Latency: envelope and env_valid reflect a sample exactly one cycle after its sample_valid; with sample_valid low, envelope holds and env_valid=0.
REQ-020 Effective off threshold = min(off_thresh, on_thresh); comparisons use the updated envelope and occur in the same cycle env_valid is raised.
REQ-021 Gate FSM states IDLE (gate=0), ON (gate=1), HOLD (gate=1); state changes only on env_valid cycles.
REQ-022 IDLE -> ON when envelope >= on_thresh.
REQ-023 ON -> HOLD when envelope < effective off threshold; hold counter loads HOLD_SAMPLES-1.
REQ-024 HOLD -> ON when envelope >= on_thresh (counter discarded); HOLD -> IDLE when counter = 0 and envelope < effective off threshold; otherwise counter decrements by 1 (saturating at 0).
REQ-025 In HOLD with envelope between the thresholds, state stays HOLD; counter continues decrementing; no IDLE transition until envelope is below the off threshold.
REQ-026 on_thresh = 0 SHALL force IDLE -> ON on the first env_valid cycle.
REQ-027 a, r, on_thresh, off_thresh may change at any time; new values take effect on the next sample_valid.

Reset
REQ-028 rst low SHALL immediately clear acc, envelope, env_valid, gate, hold counter and set state IDLE, regardless of clock.
REQ-029 A sample_valid coinciding with rst low is discarded; first sample after release of reset behaves as from power-up.

Configuration
REQ-030 Macro ENVELOPE_FOLLOWER_PEAK_EN: when defined, adds output peak (8 bits) holding the maximum rect seen since the last IDLE -> ON transition, loaded with that sample's rect on the transition, updated on env_valid cycles, reset to 0.
REQ-031 Without ENVELOPE_FOLLOWER_PEAK_EN, the peak port and its logic SHALL be absent and all other behaviour identical.

Verification
REQ-032 a=0, r=0, sample=100 valid once -> next cycle envelope=100, env_valid=1 for one cycle; then sample=-128 -> envelope=127.
REQ-033 a=1, acc=0, sample=127 on three strobes -> envelope 63, 95, 111.
REQ-034 a=0, r=0, on_thresh=64, off_thresh=32, HOLD_SAMPLES=4: sample=100 -> gate rises with env_valid; four samples of 0 -> gate stays 1; fifth sample of 0 -> gate falls.
REQ-035 Same setup, in HOLD after two zero samples, sample=80 -> state ON, gate stays 1, later four more zero samples required before the fifth drops gate.
REQ-036 off_thresh=200, on_thresh=64, envelope 100 then 50 -> HOLD entered at 50 (effective off threshold 64), not at 100.
REQ-037 gate=1, envelope=100, rst pulled low mid-cycle -> envelope=0, gate=0, env_valid=0 before the next clock edge; with ENVELOPE_FOLLOWER_PEAK_EN peak=0.

Source files
------------

// File: rtl/envelope_follower.sv
// Audio envelope follower: rectify, asymmetric one-pole smoothing, and a hysteretic gate with hold time.
// Optional peak output is enabled by defining ENVELOPE_FOLLOWER_PEAK_EN.
module envelope_follower #(
    parameter int unsigned HOLD_SAMPLES = 441,
    parameter int unsigned HOLD_BITS    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic signed [7:0] sample,
    input  logic [3:0]        a,
    input  logic [3:0]        r,
    input  logic [7:0]        on_thresh,
    input  logic [7:0]        off_thresh,
    output logic [7:0]        envelope,
    output logic              env_valid,
    output logic              gate
`ifdef ENVELOPE_FOLLOWER_PEAK_EN
    ,
    output logic [7:0]        peak
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        HOLD
    } state_t;

    localparam logic [HOLD_BITS-1:0] HOLD_LOAD = HOLD_BITS'(HOLD_SAMPLES - 1);

    state_t               state_q, state_d;
    logic [HOLD_BITS-1:0] cnt_q, cnt_d;
    logic [15:0]          acc_q, acc_d;
    logic                 valid_q;
    logic [7:0]           rect;
    logic [15:0]          target;
    logic [15:0]          up_step, dn_step;
    logic [7:0]           env_new;
    logic [7:0]           eff_off;

    // -128 has no positive 8-bit counterpart, so it clamps to 127
    always_comb begin
        rect = '0;
        if (sample == -8'sd128)
            rect = 8'd127;
        else if (sample[7])
            rect = 8'(-sample);
        else
            rect = 8'(sample);
    end

    assign target = {rect, 8'h00};

    // A shifted difference of zero still moves one LSB so the filter always converges
    always_comb begin
        up_step = (target - acc_q) >> a;
        dn_step = (acc_q - target) >> r;
        if (up_step == '0)
            up_step = 16'd1;
        if (dn_step == '0)
            dn_step = 16'd1;
    end

    always_comb begin
        acc_d = acc_q;
        if (sample_valid) begin
            if (target > acc_q)
                acc_d = acc_q + up_step;
            else if (target < acc_q)
                acc_d = acc_q - dn_step;
        end
    end

    assign env_new = acc_d[15:8];
    assign eff_off = (off_thresh < on_thresh) ? off_thresh : on_thresh;

    // Gate decisions use the post-update envelope so they appear alongside env_valid
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sample_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (env_new >= on_thresh)
                        state_d = ON;
                end
                ON: begin
                    if (env_new < eff_off) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (env_new >= on_thresh) begin
                        state_d = ON;
                        cnt_d   = '0;
                    end else if ((cnt_q == '0) && (env_new < eff_off)) begin
                        state_d = IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '0;
            valid_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            valid_q <= sample_valid;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign envelope  = acc_q[15:8];
    assign env_valid = valid_q;
    assign gate      = (state_q != IDLE);

`ifdef ENVELOPE_FOLLOWER_PEAK_EN
    logic [7:0] peak_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_q <= '0;
        end else if (sample_valid) begin
            if ((state_q == IDLE) && (state_d == ON))
                peak_q <= rect;
            else if ((state_q != IDLE) && (rect > peak_q))
                peak_q <= rect;
        end
    end

    assign peak = peak_q;
`endif

endmodule

// File: tb/tb_envelope_follower.sv
// Directed bench for envelope_follower: vector table plus convergence and reset sequences.
module tb_envelope_follower;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sample_valid = 1'b0;
    logic signed [7:0] sample = '0;
    logic [3:0]        a = '0;
    logic [3:0]        r = '0;
    logic [7:0]        on_thresh = 8'd64;
    logic [7:0]        off_thresh = 8'd32;
    logic [7:0]        envelope;
    logic              env_valid;
    logic              gate;
`ifdef ENVELOPE_FOLLOWER_PEAK_EN
    logic [7:0]        peak;
`endif

    int checks = 0;
    int errors = 0;

    envelope_follower #(
        .HOLD_SAMPLES(4),
        .HOLD_BITS   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .sample      (sample),
        .a           (a),
        .r           (r),
        .on_thresh   (on_thresh),
        .off_thresh  (off_thresh),
        .envelope    (envelope),
        .env_valid   (env_valid),
        .gate        (gate)
`ifdef ENVELOPE_FOLLOWER_PEAK_EN
        ,
        .peak        (peak)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] s;
        logic [3:0]        a;
        logic [3:0]        r;
        logic [7:0]        on;
        logic [7:0]        off;
        logic [7:0]        env;
        logic              gate;
    } vec_t;

    localparam int NV = 37;
    vec_t vecs[NV];

    function automatic vec_t mk(input int s, input int aa, input int rr, input int on,
                                input int off, input int env, input int g);
        vec_t v;
        v.s    = 8'(s);
        v.a    = 4'(aa);
        v.r    = 4'(rr);
        v.on   = 8'(on);
        v.off  = 8'(off);
        v.env  = 8'(env);
        v.gate = 1'(g);
        return v;
    endfunction

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // One sample strobe; returns at the following negedge, inside the env_valid cycle
    task automatic strobe(input logic signed [7:0] s, input logic [3:0] aa, input logic [3:0] rr,
                          input logic [7:0] on, input logic [7:0] off);
        @(negedge clk);
        sample       = s;
        a            = aa;
        r            = rr;
        on_thresh    = on;
        off_thresh   = off;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        // Basic attack/release and hold count
        vecs[0]  = mk( 100, 0, 0, 64, 32, 100, 1);
        vecs[1]  = mk(-128, 0, 0, 64, 32, 127, 1);
        vecs[2]  = mk(  -5, 0, 0, 64, 32,   5, 1);
        vecs[3]  = mk(   0, 0, 0, 64, 32,   0, 1);
        vecs[4]  = mk(   0, 0, 0, 64, 32,   0, 1);
        vecs[5]  = mk(   0, 0, 0, 64, 32,   0, 1);
        vecs[6]  = mk(   0, 0, 0, 64, 32,   0, 0);
        vecs[7]  = mk(   0, 0, 0, 64, 32,   0, 0);
        // Slow attack then slow release into hold
        vecs[8]  = mk( 127, 1, 0, 64, 32,  63, 0);
        vecs[9]  = mk( 127, 1, 0, 64, 32,  95, 1);
        vecs[10] = mk( 127, 1, 0, 64, 32, 111, 1);
        vecs[11] = mk(   0, 1, 2, 64, 32,  83, 1);
        vecs[12] = mk(   0, 1, 2, 64, 32,  62, 1);
        vecs[13] = mk(   0, 1, 2, 64, 32,  46, 1);
        vecs[14] = mk(   0, 1, 2, 64, 32,  35, 1);
        vecs[15] = mk(   0, 1, 2, 64, 32,  26, 1);
        vecs[16] = mk(   0, 0, 0, 64, 32,   0, 1);
        vecs[17] = mk(   0, 0, 0, 64, 32,   0, 1);
        vecs[18] = mk(   0, 0, 0, 64, 32,   0, 1);
        vecs[19] = mk(   0, 0, 0, 64, 32,   0, 0);
        // Re-trigger from hold restarts the hold count
        vecs[20] = mk( 100, 0, 0, 64, 32, 100, 1);
        vecs[21] = mk(   0, 0, 0, 64, 32,   0, 1);
        vecs[22] = mk(   0, 0, 0, 64, 32,   0, 1);
        vecs[23] = mk(  80, 0, 0, 64, 32,  80, 1);
        vecs[24] = mk(   0, 0, 0, 64, 32,   0, 1);
        vecs[25] = mk(   0, 0, 0, 64, 32,   0, 1);
        vecs[26] = mk(   0, 0, 0, 64, 32,   0, 1);
        vecs[27] = mk(   0, 0, 0, 64, 32,   0, 1);
        vecs[28] = mk(   0, 0, 0, 64, 32,   0, 0);
        // off above on: effective off threshold is on_thresh
        vecs[29] = mk( 100, 0, 0, 64, 200, 100, 1);
        vecs[30] = mk(  50, 0, 0, 64, 200,  50, 1);
        vecs[31] = mk(   0, 0, 0, 64, 200,   0, 1);
        vecs[32] = mk(   0, 0, 0, 64, 200,   0, 1);
        vecs[33] = mk(   0, 0, 0, 64, 200,   0, 1);
        vecs[34] = mk(   0, 0, 0, 64, 200,   0, 0);
        // on_thresh of zero opens immediately and never closes
        vecs[35] = mk(   0, 0, 0,  0, 32,   0, 1);
        vecs[36] = mk(   0, 0, 0,  0, 32,   0, 1);

        #3;
        chk("reset_envelope", int'(envelope), 0);
        chk("reset_env_valid", int'(env_valid), 0);
        chk("reset_gate", int'(gate), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_env_valid", int'(env_valid), 0);

        for (int i = 0; i < NV; i++) begin
            strobe(vecs[i].s, vecs[i].a, vecs[i].r, vecs[i].on, vecs[i].off);
            chk($sformatf("v%0d_env_valid", i), int'(env_valid), 1);
            chk($sformatf("v%0d_envelope", i), int'(envelope), int'(vecs[i].env));
            chk($sformatf("v%0d_gate", i), int'(gate), int'(vecs[i].gate));
            @(negedge clk);
            chk($sformatf("v%0d_env_valid_drop", i), int'(env_valid), 0);
            chk($sformatf("v%0d_envelope_hold", i), int'(envelope), int'(vecs[i].env));
        end

        // Mid-cycle asynchronous reset with gate open
        strobe(8'sd100, 4'd0, 4'd0, 8'd64, 8'd32);
        chk("pre_reset_envelope", int'(envelope), 100);
        chk("pre_reset_gate", int'(gate), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_envelope", int'(envelope), 0);
        chk("async_reset_gate", int'(gate), 0);
        chk("async_reset_env_valid", int'(env_valid), 0);
        // Strobe while in reset must be discarded
        strobe(8'sd100, 4'd0, 4'd0, 8'd64, 8'd32);
        chk("reset_strobe_env_valid", int'(env_valid), 0);
        chk("reset_strobe_envelope", int'(envelope), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_release_envelope", int'(envelope), 0);
        chk("post_release_gate", int'(gate), 0);

        // Slowest attack: shifted step is zero, so acc creeps up one LSB per sample
        for (int i = 1; i <= 260; i++) begin
            strobe(8'sd1, 4'd15, 4'd0, 8'd64, 8'd32);
            if (i == 255) chk("creep_255", int'(envelope), 0);
            if (i == 256) chk("creep_256", int'(envelope), 1);
        end
        chk("creep_settled", int'(envelope), 1);
        chk("creep_gate", int'(gate), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
